// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the memory-access stage: access sizes and FSM states.
package mem_access_stage_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/mem_access_stage_load_formatter.sv
// Combinational little-endian load formatter: lane select plus sign/zero extension.
module load_formatter
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned NB_DATA = 32
) (
  input  logic [NB_DATA-1:0] rdata_i,
  input  logic [1:0]         addr_i,
  input  size_e              size_i,
  input  logic               unsigned_i,
  output logic [NB_DATA-1:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata_i[7:0];
    half_lane = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (addr_i)
      2'd0: byte_lane = rdata_i[7:0];
      2'd1: byte_lane = rdata_i[15:8];
      2'd2: byte_lane = rdata_i[23:16];
      2'd3: byte_lane = rdata_i[31:24];
      default: byte_lane = rdata_i[7:0];
    endcase

    data_o = rdata_i;
    case (size_i)
      SIZE_BYTE: data_o = {{(NB_DATA-8){byte_lane[7] & ~unsigned_i}}, byte_lane};
      SIZE_HALF: data_o = {{(NB_DATA-16){half_lane[15] & ~unsigned_i}}, half_lane};
      default:   data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: request/ack data-memory port, load/store
// formatting and a registered single-cycle writeback bundle.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_REG  = 5
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [NB_DATA-1:0] alu_result_i,
  input  logic [NB_DATA-1:0] data_rb_i,
  input  logic [NB_REG-1:0]  write_reg_i,
  input  logic               reg_write_i,
  input  logic               mem_read_i,
  input  logic               mem_write_i,
  input  logic [1:0]         size_i,
  input  logic               unsigned_i,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [NB_DATA-1:0] dmem_addr_o,
  output logic [3:0]         dmem_be_o,
  output logic [NB_DATA-1:0] dmem_wdata_o,
  input  logic               dmem_ack_i,
  input  logic [NB_DATA-1:0] dmem_rdata_i,
  output logic               wb_valid_o,
  output logic [NB_DATA-1:0] wb_data_o,
  output logic [NB_REG-1:0]  wb_reg_o,
  output logic               wb_reg_write_o,
  output logic               align_err_o
);

  state_e              state_q;
  logic [1:0]          addr_lo_q;
  size_e               size_q;
  logic                unsigned_q;
  logic                load_q;
  logic                reg_write_q;
  logic [NB_REG-1:0]   reg_q;

  size_e               size_in;
  logic                mem_op;
  logic                misaligned;
  logic [3:0]          be_d;
  logic [NB_DATA-1:0]  wdata_d;
  logic [NB_DATA-1:0]  load_data;

  assign size_in = size_e'(size_i);
  assign mem_op  = mem_read_i | mem_write_i;
  assign ready_o = (state_q == ST_IDLE);

  always_comb begin
    misaligned = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = data_rb_i;
    case (size_in)
      SIZE_BYTE: begin
        be_d    = 4'b0001 << alu_result_i[1:0];
        wdata_d = {4{data_rb_i[7:0]}};
      end
      SIZE_HALF: begin
        misaligned = alu_result_i[0];
        be_d       = alu_result_i[1] ? 4'b1100 : 4'b0011;
        wdata_d    = {2{data_rb_i[15:0]}};
      end
      SIZE_WORD: misaligned = |alu_result_i[1:0];
      SIZE_RSVD: misaligned = 1'b1;
      default:   misaligned = 1'b1;
    endcase
  end

  load_formatter #(.NB_DATA(NB_DATA)) u_load_formatter (
    .rdata_i    (dmem_rdata_i),
    .addr_i     (addr_lo_q),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .data_o     (load_data)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= ST_IDLE;
      addr_lo_q      <= '0;
      size_q         <= SIZE_BYTE;
      unsigned_q     <= 1'b0;
      load_q         <= 1'b0;
      reg_write_q    <= 1'b0;
      reg_q          <= '0;
      dmem_req_o     <= 1'b0;
      dmem_we_o      <= 1'b0;
      dmem_addr_o    <= '0;
      dmem_be_o      <= '0;
      dmem_wdata_o   <= '0;
      wb_valid_o     <= 1'b0;
      wb_data_o      <= '0;
      wb_reg_o       <= '0;
      wb_reg_write_o <= 1'b0;
      align_err_o    <= 1'b0;
    end else begin
      wb_valid_o  <= 1'b0;
      align_err_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            if (!mem_op) begin
              wb_valid_o     <= 1'b1;
              wb_data_o      <= alu_result_i;
              wb_reg_o       <= write_reg_i;
              wb_reg_write_o <= reg_write_i;
            end else if (misaligned) begin
              wb_valid_o     <= 1'b1;
              wb_data_o      <= '0;
              wb_reg_o       <= write_reg_i;
              wb_reg_write_o <= 1'b0;
              align_err_o    <= 1'b1;
            end else begin
              // A load wins when both controls are set, so it never writes memory.
              addr_lo_q    <= alu_result_i[1:0];
              size_q       <= size_in;
              unsigned_q   <= unsigned_i;
              load_q       <= mem_read_i;
              reg_write_q  <= reg_write_i;
              reg_q        <= write_reg_i;
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= mem_write_i & ~mem_read_i;
              dmem_addr_o  <= {alu_result_i[NB_DATA-1:2], 2'b00};
              dmem_be_o    <= be_d;
              dmem_wdata_o <= wdata_d;
              state_q      <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (dmem_ack_i) begin
            dmem_req_o     <= 1'b0;
            dmem_we_o      <= 1'b0;
            wb_valid_o     <= 1'b1;
            wb_reg_o       <= reg_q;
            wb_data_o      <= load_q ? load_data : '0;
            wb_reg_write_o <= load_q & reg_write_q;
            state_q        <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios then random traffic against
// a byte-level memory model with random acknowledge latency.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        valid_i, ready_o;
  logic [31:0] alu_result_i, data_rb_i;
  logic [4:0]  write_reg_i;
  logic        reg_write_i, mem_read_i, mem_write_i, unsigned_i;
  logic [1:0]  size_i;
  logic        dmem_req_o, dmem_we_o, dmem_ack_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic        wb_valid_o, wb_reg_write_o, align_err_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_reg_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] mem [16];

  typedef struct {
    logic        rd, wr, uns, rw;
    logic [31:0] addr, rb;
    logic [1:0]  size;
    logic [4:0]  rg;
  } op_t;

  always #5 clk = ~clk;

  mem_access_stage #(.NB_DATA(32), .NB_REG(5)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
    .alu_result_i(alu_result_i), .data_rb_i(data_rb_i), .write_reg_i(write_reg_i),
    .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .size_i(size_i), .unsigned_i(unsigned_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o),
    .wb_reg_o(wb_reg_o), .wb_reg_write_o(wb_reg_write_o), .align_err_o(align_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_err(input logic [31:0] a, input logic [1:0] s);
    int off = int'(a[1:0]);
    return (s == 2'd3) || ((off % nbytes(s)) != 0);
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [1:0] s);
    logic [3:0] be = '0;
    int off = int'(a[1:0]);
    for (int k = 0; k < 4; k++)
      if (k >= off && k < off + nbytes(s)) be[k] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] rb, input logic [1:0] s);
    logic [31:0] w;
    int n = nbytes(s);
    for (int k = 0; k < 4; k++) w[8*k +: 8] = rb[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [31:0] a,
                                           input logic [1:0] s, input logic uns);
    logic [63:0] v, mask;
    int n = nbytes(s);
    v    = {32'd0, word} >> (8 * int'(a[1:0]));
    mask = (64'd1 << (8 * n)) - 64'd1;
    v    = v & mask;
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic drive(input op_t o);
    valid_i      = 1'b1;
    alu_result_i = o.addr;
    data_rb_i    = o.rb;
    write_reg_i  = o.rg;
    reg_write_i  = o.rw;
    mem_read_i   = o.rd;
    mem_write_i  = o.wr;
    size_i       = o.size;
    unsigned_i   = o.uns;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input op_t o, input int delay);
    bit memop, err, ld;
    int hi;
    logic [3:0]  be;
    logic [31:0] wd, word;
    memop = o.rd | o.wr;
    ld    = o.rd;
    err   = memop && is_err(o.addr, o.size);
    drive(o);
    step();
    valid_i = 1'b0;
    if (!memop || err) begin
      chk1("wb_valid", wb_valid_o, 1'b1);
      chk1("no_req", dmem_req_o, 1'b0);
      chk1("ready_idle", ready_o, 1'b1);
      chk1("align_err", align_err_o, err);
      chk("wb_reg", {27'd0, wb_reg_o}, {27'd0, o.rg});
      if (err) chk1("err_rw", wb_reg_write_o, 1'b0);
      else begin
        chk("pass_data", wb_data_o, o.addr);
        chk1("pass_rw", wb_reg_write_o, o.rw);
      end
      step();
      chk1("wb_single", wb_valid_o, 1'b0);
      chk1("err_single", align_err_o, 1'b0);
    end else begin
      be = exp_be(o.addr, o.size);
      wd = exp_wdata(o.rb, o.size);
      chk1("req", dmem_req_o, 1'b1);
      chk1("we", dmem_we_o, o.wr & ~o.rd);
      chk("addr", dmem_addr_o, {o.addr[31:2], 2'b00});
      chk("be", {28'd0, dmem_be_o}, {28'd0, be});
      if (!ld) chk("wdata", dmem_wdata_o, wd);
      chk1("ready_busy", ready_o, 1'b0);
      hi = 1;
      repeat (delay) begin
        step();
        if (dmem_req_o) hi++;
        chk1("wb_early", wb_valid_o, 1'b0);
        chk("addr_hold", dmem_addr_o, {o.addr[31:2], 2'b00});
      end
      word = mem[o.addr[5:2]];
      dmem_ack_i   = 1'b1;
      dmem_rdata_i = ld ? word : $urandom;
      step();
      dmem_ack_i = 1'b0;
      chk("req_cycles", 32'(hi), 32'(delay + 1));
      chk1("wb_valid_mem", wb_valid_o, 1'b1);
      chk1("req_drop", dmem_req_o, 1'b0);
      chk1("we_drop", dmem_we_o, 1'b0);
      chk1("ready_back", ready_o, 1'b1);
      chk1("mem_align_err", align_err_o, 1'b0);
      chk("wb_reg_mem", {27'd0, wb_reg_o}, {27'd0, o.rg});
      chk1("wb_rw_mem", wb_reg_write_o, ld ? o.rw : 1'b0);
      chk("wb_data_mem", wb_data_o, ld ? exp_load(word, o.addr, o.size, o.uns) : 32'd0);
      if (!ld)
        for (int k = 0; k < 4; k++)
          if (be[k]) mem[o.addr[5:2]][8*k +: 8] = wd[8*k +: 8];
      step();
      chk1("wb_single_mem", wb_valid_o, 1'b0);
    end
  endtask

  initial begin
    op_t o, b;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    rst_n_i = 1'b0; valid_i = 1'b0; alu_result_i = '0; data_rb_i = '0;
    write_reg_i = '0; reg_write_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    size_i = '0; unsigned_i = 1'b0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    #12;
    chk1("rst_ready", ready_o, 1'b1);
    chk1("rst_req", dmem_req_o, 1'b0);
    chk1("rst_wb_valid", wb_valid_o, 1'b0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    chk("rst_be", {28'd0, dmem_be_o}, 32'd0);
    rst_n_i = 1'b1;
    step();

    // Passthrough
    o = '{rd:0, wr:0, uns:0, rw:1, addr:32'h0000_1234, rb:32'h0, size:2'd2, rg:5'd7};
    run_op(o, 0);

    // Store byte at 0x103 with three wait cycles
    o = '{rd:0, wr:1, uns:0, rw:1, addr:32'h0000_0103, rb:32'hAABB_CCDD, size:2'd0, rg:5'd3};
    run_op(o, 3);

    // Signed and unsigned half loads from 0x202
    mem[0] = 32'h8001_7FFF;
    o = '{rd:1, wr:0, uns:0, rw:1, addr:32'h0000_0202, rb:32'h0, size:2'd1, rg:5'd4};
    run_op(o, 1);
    chk("half_signed_lit", wb_data_o, 32'hFFFF_8001);
    o.uns = 1'b1;
    run_op(o, 0);
    chk("half_unsigned_lit", wb_data_o, 32'h0000_8001);

    // Misaligned word and reserved size
    o = '{rd:1, wr:0, uns:0, rw:1, addr:32'h0000_0302, rb:32'h0, size:2'd2, rg:5'd5};
    run_op(o, 0);
    o = '{rd:0, wr:1, uns:0, rw:1, addr:32'h0000_0300, rb:32'h1, size:2'd3, rg:5'd6};
    run_op(o, 0);

    // Stall: next bundle held on valid_i during the access
    o = '{rd:0, wr:1, uns:0, rw:1, addr:32'h0000_0010, rb:32'h1357_9BDF, size:2'd2, rg:5'd8};
    b = '{rd:0, wr:0, uns:0, rw:1, addr:32'hCAFE_0001, rb:32'h0, size:2'd2, rg:5'd9};
    drive(o);
    step();
    drive(b);
    chk1("stall_req", dmem_req_o, 1'b1);
    repeat (2) begin
      step();
      chk1("stall_wb", wb_valid_o, 1'b0);
      chk1("stall_ready", ready_o, 1'b0);
      chk("stall_wdata", dmem_wdata_o, 32'h1357_9BDF);
    end
    dmem_ack_i = 1'b1;
    step();
    dmem_ack_i = 1'b0;
    chk1("stall_wb_a", wb_valid_o, 1'b1);
    chk("stall_reg_a", {27'd0, wb_reg_o}, 32'd8);
    chk1("stall_ready_a", ready_o, 1'b1);
    step();
    valid_i = 1'b0;
    chk1("stall_wb_b", wb_valid_o, 1'b1);
    chk("stall_data_b", wb_data_o, 32'hCAFE_0001);
    chk("stall_reg_b", {27'd0, wb_reg_o}, 32'd9);
    step();
    chk1("stall_wb_none", wb_valid_o, 1'b0);
    mem[4] = 32'h1357_9BDF;

    // Reset mid-access, then a late ack
    o = '{rd:1, wr:0, uns:0, rw:1, addr:32'h0000_0020, rb:32'h0, size:2'd2, rg:5'd10};
    drive(o);
    step();
    valid_i = 1'b0;
    chk1("mid_req", dmem_req_o, 1'b1);
    #2 rst_n_i = 1'b0;
    #1;
    chk1("arst_req", dmem_req_o, 1'b0);
    chk1("arst_we", dmem_we_o, 1'b0);
    chk("arst_addr", dmem_addr_o, 32'd0);
    chk("arst_be", {28'd0, dmem_be_o}, 32'd0);
    chk1("arst_wb_valid", wb_valid_o, 1'b0);
    chk("arst_wb_reg", {27'd0, wb_reg_o}, 32'd0);
    chk1("arst_ready", ready_o, 1'b1);
    #3 rst_n_i = 1'b1;
    step();
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 32'hDEAD_BEEF;
    step();
    dmem_ack_i = 1'b0;
    chk1("late_ack_wb", wb_valid_o, 1'b0);
    chk1("late_ack_req", dmem_req_o, 1'b0);
    chk1("late_ack_ready", ready_o, 1'b1);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      int kind;
      kind   = $urandom_range(0, 3);
      o.rd   = (kind == 1) || (kind == 3);
      o.wr   = (kind == 2) || (kind == 3);
      o.addr = $urandom;
      if ($urandom_range(0, 2) != 0) o.addr[1:0] = 2'b00;
      o.rb   = $urandom;
      o.size = 2'($urandom_range(0, 3));
      o.uns  = 1'($urandom_range(0, 1));
      o.rw   = 1'($urandom_range(0, 1));
      o.rg   = 5'($urandom_range(0, 31));
      run_op(o, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
